alu_operand_regs: RTL and testbench

ALU_OPERAND_REGS -- requirements
Module: alu_operand_regs

---
 rtl/alu_operand_regs_pkg.sv | 25 ++
 rtl/alu_operand_regs_operand_reg.sv | 21 ++
 rtl/alu_operand_regs.sv | 61 ++++++
 tb/tb_alu_operand_regs.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_regs_pkg.sv
// Shared definitions for the ALU operand register block and the
// adder/subtractor stage that consumes its operands.
package alu_operand_regs_pkg;

  localparam int DATA_W = 8;
  localparam int FLAG_W = 2;

  // Operation select encoding, identical to the adder/subtractor stage.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // 9-bit add/subtract result; bit DATA_W is the carry (no-borrow on subtract).
  function automatic logic [DATA_W:0] addsub(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic              op);
    logic [DATA_W:0] r;
    if (op == OP_SUB) begin
      r = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
    end else begin
      r = {1'b0, a} + {1'b0, b};
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_operand_regs_operand_reg.sv
// Loadable operand register with asynchronous active-low clear.
module operand_reg
  import alu_operand_regs_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  // Capture the bus value when load is strobed, otherwise hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= '0;
    end else if (i_load) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/alu_operand_regs.sv
// Operand A/B registers feeding the adder/subtractor, a tri-state bus
// driver for A, and registered carry/zero flags.
module alu_operand_regs
  import alu_operand_regs_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_bus,
  input  logic              i_load_a,
  input  logic              i_load_b,
  input  logic              i_send_a,
  input  logic              i_subtract,
  input  logic              i_latch_flags,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic [DATA_W-1:0] o_bus,
  output logic              o_carry,
  output logic              o_zero
);

  logic            load_a_eff;
  logic [DATA_W:0] result;

  // When A is driving the shared bus, a load of A would just read A back;
  // suppressing it keeps A stable rather than relying on the bus loop.
  assign load_a_eff = i_load_a & ~i_send_a;

  operand_reg u_reg_a (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (load_a_eff),
    .i_d     (i_bus),
    .o_q     (o_a)
  );

  operand_reg u_reg_b (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (i_load_b),
    .i_d     (i_bus),
    .o_q     (o_b)
  );

  // Bus driver: A when sending and not in reset, high impedance otherwise.
  assign o_bus = (i_send_a && i_rst_n) ? o_a : {DATA_W{1'bz}};

  // Same arithmetic as the adder/subtractor stage, on the pre-edge operands.
  assign result = addsub(o_a, o_b, i_subtract);

  // Flags update only on a latch strobe and hold otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_carry <= 1'b0;
      o_zero  <= 1'b0;
    end else if (i_latch_flags) begin
      o_carry <= result[DATA_W];
      o_zero  <= (result[DATA_W-1:0] == '0);
    end
  end

endmodule

// File: tb/tb_alu_operand_regs.sv
// Self-checking bench for alu_operand_regs: directed scenarios plus a
// randomized run against a behavioural model.
module tb_alu_operand_regs;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [7:0] i_bus;
  logic       i_load_a;
  logic       i_load_b;
  logic       i_send_a;
  logic       i_subtract;
  logic       i_latch_flags;
  logic [7:0] o_a;
  logic [7:0] o_b;
  tri1  [7:0] bus_w;   // pulled high so a released bus reads as 8'hFF
  logic       o_carry;
  logic       o_zero;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_a, m_b, m_c, m_z;

  // Clock block
  always #5 i_clk = ~i_clk;

  alu_operand_regs dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_bus         (i_bus),
    .i_load_a      (i_load_a),
    .i_load_b      (i_load_b),
    .i_send_a      (i_send_a),
    .i_subtract    (i_subtract),
    .i_latch_flags (i_latch_flags),
    .o_a           (o_a),
    .o_b           (o_b),
    .o_bus         (bus_w),
    .o_carry       (o_carry),
    .o_zero        (o_zero)
  );

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bus_expect();
    return (i_send_a && i_rst_n) ? m_a : 255;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_a"},     9'(o_a),     9'(m_a));
    check({tag, "_b"},     9'(o_b),     9'(m_b));
    check({tag, "_carry"}, 9'(o_carry), 9'(m_c));
    check({tag, "_zero"},  9'(o_zero),  9'(m_z));
    check({tag, "_bus"},   9'(bus_w),   9'(bus_expect()));
  endtask

  task automatic drive(input logic [7:0] bus, input logic la, input logic lb,
                       input logic sa, input logic sub, input logic lf);
    i_bus         = bus;
    i_load_a      = la;
    i_load_b      = lb;
    i_send_a      = sa;
    i_subtract    = sub;
    i_latch_flags = lf;
  endtask

  task automatic idle();
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock edge: advance the model from the strobes, then compare.
  task automatic tick(input string tag);
    int sum;
    @(posedge i_clk);
    if (i_rst_n) begin
      if (i_latch_flags) begin
        if (i_subtract) begin
          m_c = (m_a >= m_b) ? 1 : 0;
          m_z = (m_a == m_b) ? 1 : 0;
        end else begin
          sum = m_a + m_b;
          m_c = (sum > 255) ? 1 : 0;
          m_z = ((sum % 256) == 0) ? 1 : 0;
        end
      end
      if (i_load_a && !i_send_a) m_a = i_bus;
      if (i_load_b) m_b = i_bus;
    end
    #1;
    check_all(tag);
  endtask

  task automatic load_a(input logic [7:0] v);
    drive(v, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("load_a");
    idle();
  endtask

  task automatic load_b(input logic [7:0] v);
    drive(v, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("load_b");
    idle();
  endtask

  task automatic latch(input logic sub);
    drive(8'h00, 1'b0, 1'b0, 1'b0, sub, 1'b1);
    tick("latch");
    idle();
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_c = 0; m_z = 0;
  endtask

  initial begin
    model_reset();
    idle();
    i_rst_n = 1'b1;
    #2;
    // Asynchronous reset with send_a high: bus must be released.
    i_send_a = 1'b1;
    i_rst_n  = 1'b0;
    #1;
    check_all("reset0");
    #4;
    i_rst_n  = 1'b1;
    i_send_a = 1'b0;
    // Releasing edge with no strobes: nothing changes.
    tick("rst_release");

    // Load A and B, then drive A onto the bus.
    load_a(8'h3C);
    load_b(8'h05);
    check("load_a_val", 9'(o_a), 9'h03C);
    check("load_b_val", 9'(o_b), 9'h005);
    i_send_a = 1'b1;
    #1;
    check("send_bus", 9'(bus_w), 9'h03C);
    i_send_a = 1'b0;
    #1;
    check("release_bus", 9'(bus_w), 9'h0FF);

    // Add flags
    load_a(8'hF0); load_b(8'h10); latch(1'b0);
    check("add_ovf_carry", 9'(o_carry), 9'h1);
    check("add_ovf_zero",  9'(o_zero),  9'h1);
    load_a(8'h01); load_b(8'h02); latch(1'b0);
    check("add_small_carry", 9'(o_carry), 9'h0);
    check("add_small_zero",  9'(o_zero),  9'h0);

    // Subtract flags
    load_a(8'h05); load_b(8'h05); latch(1'b1);
    check("sub_eq_carry", 9'(o_carry), 9'h1);
    check("sub_eq_zero",  9'(o_zero),  9'h1);
    load_a(8'h03); load_b(8'h05); latch(1'b1);
    check("sub_borrow_carry", 9'(o_carry), 9'h0);
    check("sub_borrow_zero",  9'(o_zero),  9'h0);

    // Load A and latch on the same edge: flags use the old A.
    load_a(8'h01); load_b(8'hFF);
    drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("simul");
    idle();
    check("simul_carry", 9'(o_carry), 9'h1);
    check("simul_zero",  9'(o_zero),  9'h1);
    check("simul_a",     9'(o_a),     9'h000);

    // Flags hold while operands change.
    load_b(8'h42);
    check("hold_carry", 9'(o_carry), 9'h1);
    check("hold_zero",  9'(o_zero),  9'h1);

    // Bus loopback: A keeps its value.
    load_a(8'h77);
    drive(8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick("loopback");
    idle();
    check("loopback_a", 9'(o_a), 9'h077);
    // Both loads on one edge.
    drive(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("both_load");
    idle();
    check("both_a", 9'(o_a), 9'h0A5);
    check("both_b", 9'(o_b), 9'h0A5);

    // Reset mid-operation with strobes pending across an edge.
    load_a(8'h5A);
    load_b(8'hC3);
    latch(1'b1);
    drive(8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    check_all("mid_reset");
    tick("reset_edge");
    idle();
    #2;
    i_rst_n = 1'b1;
    tick("post_reset_idle");
    load_a(8'h9E);
    check("post_reset_load", 9'(o_a), 9'h09E);

    // Randomized run against the model.
    for (int n = 0; n < 400; n++) begin
      drive(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick("rand");
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
